// File: rtl/ttt_move_engine.sv
// Sequential N x N tic-tac-toe move generator. It scans one line per cycle and then
// picks a move by priority: win, block, centre, corner, first free cell.
module ttt_move_engine #(
  parameter int unsigned N    = 3,
  parameter int unsigned RC_W = ($clog2(N) > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2*N*N-1:0] board,
  input  logic [1:0]       player,
  output logic             busy,
  output logic             done,
  output logic             move_valid,
  output logic [RC_W-1:0]  row,
  output logic [RC_W-1:0]  col,
  output logic [1:0]       xoro
);

  localparam int unsigned BW   = 2*N*N;
  localparam int unsigned IW   = $clog2(BW);
  localparam int unsigned CW   = $clog2(N+1);
  localparam int unsigned LW   = $clog2(2*N+2);
  localparam int unsigned LAST = 2*N+1;
  localparam int unsigned MID  = (N-1)/2;

  typedef enum logic [1:0] {IDLE, SCAN, DECIDE} state_t;

  state_t          state;
  logic [BW-1:0]   board_q;
  logic [1:0]      player_q;
  logic [LW-1:0]   line_idx;
  logic            win_hit, blk_hit;
  logic [RC_W-1:0] win_r, win_c, blk_r, blk_c;
  logic            player_ok;

  function automatic logic [1:0] cell_at(input logic [BW-1:0] b, input int r, input int c);
    return b[IW'(2*(r*int'(N)+c)) +: 2];
  endfunction

  assign player_ok = (player_q == 2'b01) || (player_q == 2'b10);

  // Per-line tallies for the line currently addressed by line_idx
  logic [CW-1:0]   own_cnt, opp_cnt;
  logic            emp_found;
  logic [RC_W-1:0] emp_r, emp_c;
  logic            line_win, line_blk;
  int              ln_r, ln_c;
  logic [1:0]      ln_cell;

  always_comb begin
    own_cnt   = '0;
    opp_cnt   = '0;
    emp_found = 1'b0;
    emp_r     = '0;
    emp_c     = '0;
    ln_r      = 0;
    ln_c      = 0;
    ln_cell   = 2'b00;
    for (int i = 0; i < int'(N); i++) begin
      if (int'(line_idx) < int'(N)) begin
        ln_r = int'(line_idx);
        ln_c = i;
      end else if (int'(line_idx) < 2*int'(N)) begin
        ln_r = i;
        ln_c = int'(line_idx) - int'(N);
      end else if (int'(line_idx) == 2*int'(N)) begin
        ln_r = i;
        ln_c = i;
      end else begin
        ln_r = i;
        ln_c = int'(N) - 1 - i;
      end
      ln_cell = cell_at(board_q, ln_r, ln_c);
      if (ln_cell == 2'b00) begin
        if (!emp_found) begin
          emp_found = 1'b1;
          emp_r     = RC_W'(ln_r);
          emp_c     = RC_W'(ln_c);
        end
      end else if (player_ok && (ln_cell == player_q)) begin
        own_cnt = own_cnt + CW'(1);
      end else begin
        opp_cnt = opp_cnt + CW'(1);
      end
    end
  end

  assign line_win = emp_found && (own_cnt == CW'(N-1));
  assign line_blk = emp_found && (opp_cnt == CW'(N-1));

  // Final move selection from latched candidates and the captured board
  logic            dec_valid, found;
  logic [RC_W-1:0] dec_r, dec_c;

  always_comb begin
    dec_valid = 1'b0;
    dec_r     = '0;
    dec_c     = '0;
    found     = 1'b0;
    if (win_hit) begin
      dec_valid = 1'b1;
      dec_r     = win_r;
      dec_c     = win_c;
    end else if (blk_hit) begin
      dec_valid = 1'b1;
      dec_r     = blk_r;
      dec_c     = blk_c;
    end else if ((N % 2 == 1) && (cell_at(board_q, int'(MID), int'(MID)) == 2'b00)) begin
      dec_valid = 1'b1;
      dec_r     = RC_W'(MID);
      dec_c     = RC_W'(MID);
    end else if (cell_at(board_q, 0, 0) == 2'b00) begin
      dec_valid = 1'b1;
    end else if (cell_at(board_q, 0, int'(N)-1) == 2'b00) begin
      dec_valid = 1'b1;
      dec_c     = RC_W'(N-1);
    end else if (cell_at(board_q, int'(N)-1, 0) == 2'b00) begin
      dec_valid = 1'b1;
      dec_r     = RC_W'(N-1);
    end else if (cell_at(board_q, int'(N)-1, int'(N)-1) == 2'b00) begin
      dec_valid = 1'b1;
      dec_r     = RC_W'(N-1);
      dec_c     = RC_W'(N-1);
    end else begin
      for (int r = 0; r < int'(N); r++) begin
        for (int c = 0; c < int'(N); c++) begin
          if (!found && (cell_at(board_q, r, c) == 2'b00)) begin
            found     = 1'b1;
            dec_valid = 1'b1;
            dec_r     = RC_W'(r);
            dec_c     = RC_W'(c);
          end
        end
      end
    end
    if (!player_ok) begin
      dec_valid = 1'b0;
      dec_r     = '0;
      dec_c     = '0;
    end
  end

  // Control FSM; start is ignored while busy and during the done cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      move_valid <= 1'b0;
      row        <= '0;
      col        <= '0;
      xoro       <= 2'b00;
      board_q    <= '0;
      player_q   <= 2'b00;
      line_idx   <= '0;
      win_hit    <= 1'b0;
      blk_hit    <= 1'b0;
      win_r      <= '0;
      win_c      <= '0;
      blk_r      <= '0;
      blk_c      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !done) begin
            board_q  <= board;
            player_q <= player;
            win_hit  <= 1'b0;
            blk_hit  <= 1'b0;
            line_idx <= '0;
            busy     <= 1'b1;
            state    <= SCAN;
          end
        end
        SCAN: begin
          if (line_win && !win_hit) begin
            win_hit <= 1'b1;
            win_r   <= emp_r;
            win_c   <= emp_c;
          end
          if (line_blk && !blk_hit) begin
            blk_hit <= 1'b1;
            blk_r   <= emp_r;
            blk_c   <= emp_c;
          end
          if (line_idx == LW'(LAST)) begin
            state <= DECIDE;
          end else begin
            line_idx <= line_idx + LW'(1);
          end
        end
        DECIDE: begin
          move_valid <= dec_valid;
          row        <= dec_r;
          col        <= dec_c;
          xoro       <= player_q;
          done       <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ttt_move_engine.sv
// Scoreboard bench for ttt_move_engine: one N=3 and one N=4 instance share the clock and reset.
`timescale 1ns/1ps
module tb_ttt_move_engine;

  typedef struct packed {
    logic       v;
    logic [1:0] r;
    logic [1:0] c;
    logic [1:0] x;
  } exp_t;

  logic        clk, reset;
  logic        start3, start4, sel4;
  logic [17:0] board3;
  logic [31:0] board4;
  logic [1:0]  player3, player4;
  logic        busy3, done3, mv3, busy4, done4, mv4;
  logic [1:0]  row3, col3, xoro3, row4, col4, xoro4;
  logic        m_busy, m_done, m_mv;
  logic [1:0]  m_row, m_col, m_xoro;

  exp_t sb[$];
  int   total, bad;

  ttt_move_engine #(.N(3)) u3 (
    .clk(clk), .reset(reset), .start(start3), .board(board3), .player(player3),
    .busy(busy3), .done(done3), .move_valid(mv3), .row(row3), .col(col3), .xoro(xoro3)
  );

  ttt_move_engine #(.N(4)) u4 (
    .clk(clk), .reset(reset), .start(start4), .board(board4), .player(player4),
    .busy(busy4), .done(done4), .move_valid(mv4), .row(row4), .col(col4), .xoro(xoro4)
  );

  assign m_busy = sel4 ? busy4 : busy3;
  assign m_done = sel4 ? done4 : done3;
  assign m_mv   = sel4 ? mv4   : mv3;
  assign m_row  = sel4 ? row4  : row3;
  assign m_col  = sel4 ? col4  : col3;
  assign m_xoro = sel4 ? xoro4 : xoro3;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic exp_t mk(input logic v, input int r, input int c, input logic [1:0] x);
    exp_t e;
    e.v = v; e.r = 2'(r); e.c = 2'(c); e.x = x;
    return e;
  endfunction

  function automatic logic [31:0] put(input logic [31:0] b, input int n, input int r, input int c,
                                      input logic [1:0] v);
    logic [31:0] t;
    t = b;
    t[2*(r*n+c) +: 2] = v;
    return t;
  endfunction

  // Reference move chooser
  function automatic exp_t model(input logic [31:0] b, input logic [1:0] p, input int n);
    exp_t e;
    int wr, wc, br, bc, own, opp, er, ec, r, c, m;
    int cr[4], cc[4];
    logic [1:0] cl;
    wr = -1; wc = 0; br = -1; bc = 0;
    e = mk(1'b0, 0, 0, p);
    for (int l = 0; l < 2*n+2; l++) begin
      own = 0; opp = 0; er = -1; ec = 0;
      for (int i = 0; i < n; i++) begin
        if (l < n) begin r = l; c = i; end
        else if (l < 2*n) begin r = i; c = l - n; end
        else if (l == 2*n) begin r = i; c = i; end
        else begin r = i; c = n - 1 - i; end
        cl = b[2*(r*n+c) +: 2];
        if (cl == 2'b00) begin
          if (er < 0) begin er = r; ec = c; end
        end else if (cl == p) own++;
        else opp++;
      end
      if (er >= 0 && own == n-1 && wr < 0) begin wr = er; wc = ec; end
      if (er >= 0 && opp == n-1 && br < 0) begin br = er; bc = ec; end
    end
    m = (n-1)/2;
    cr = '{0, 0, n-1, n-1};
    cc = '{0, n-1, 0, n-1};
    if (wr >= 0) e = mk(1'b1, wr, wc, p);
    else if (br >= 0) e = mk(1'b1, br, bc, p);
    else if ((n % 2 == 1) && (b[2*(m*n+m) +: 2] == 2'b00)) e = mk(1'b1, m, m, p);
    else begin
      for (int k = 0; k < 4; k++)
        if (!e.v && b[2*(cr[k]*n+cc[k]) +: 2] == 2'b00) e = mk(1'b1, cr[k], cc[k], p);
      for (int i = 0; i < n*n; i++)
        if (!e.v && b[2*i +: 2] == 2'b00) e = mk(1'b1, i / n, i % n, p);
    end
    if (p != 2'b01 && p != 2'b10) e = mk(1'b0, 0, 0, p);
    return e;
  endfunction

  task automatic run_move(input bit use4, input logic [31:0] b, input logic [1:0] p,
                          input exp_t e, input string name);
    int n, lat, bcnt;
    bit seen;
    exp_t got, want;
    n = use4 ? 4 : 3;
    sel4 = use4;
    if (use4) begin board4 = b; player4 = p; start4 = 1'b1; end
    else begin board3 = b[17:0]; player3 = p; start3 = 1'b1; end
    sb.push_back(e);
    @(posedge clk); #1;
    start3 = 1'b0; start4 = 1'b0;
    bcnt = m_busy ? 1 : 0;
    lat = 0; seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(posedge clk); #1;
      lat++;
      if (m_done) seen = 1'b1;
      else if (m_busy) bcnt++;
    end
    want = sb.pop_front();
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s timeout: no done within 40 cycles", name);
      return;
    end
    total++;
    if (lat !== 2*n+3) begin bad++; $display("FAIL %s latency: got %0d want %0d", name, lat, 2*n+3); end
    total++;
    if (bcnt !== 2*n+3) begin bad++; $display("FAIL %s busy cycles: got %0d want %0d", name, bcnt, 2*n+3); end
    total++;
    if (m_busy !== 1'b0) begin bad++; $display("FAIL %s busy at done: got %b want 0", name, m_busy); end
    got = {m_mv, m_row, m_col, m_xoro};
    total++;
    if (got !== want)
      begin bad++; $display("FAIL %s result v/r/c/x: got %b/%0d/%0d/%b want %b/%0d/%0d/%b",
                            name, got.v, got.r, got.c, got.x, want.v, want.r, want.c, want.x); end
    // start during the done cycle must be dropped
    if (use4) start4 = 1'b1; else start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0; start4 = 1'b0;
    total++;
    if ({m_busy, m_done} !== 2'b00)
      begin bad++; $display("FAIL %s after done busy/done: got %b%b want 00", name, m_busy, m_done); end
    got = {m_mv, m_row, m_col, m_xoro};
    total++;
    if (got !== want) begin bad++; $display("FAIL %s hold: got %b want %b", name, got, want); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({busy3, done3, mv3, row3, col3, xoro3} !== 9'd0)
      begin bad++; $display("FAIL reset n3: got %b want 0", {busy3, done3, mv3, row3, col3, xoro3}); end
    total++;
    if ({busy4, done4, mv4, row4, col4, xoro4} !== 9'd0)
      begin bad++; $display("FAIL reset n4: got %b want 0", {busy4, done4, mv4, row4, col4, xoro4}); end
    reset = 1'b0;
  endtask

  task automatic test_priority3();
    logic [31:0] b;
    int pat[9];
    run_move(1'b0, 32'd0, 2'b10, mk(1'b1, 1, 1, 2'b10), "centre_empty");
    b = 32'd0;
    b = put(b, 3, 0, 0, 2'b10); b = put(b, 3, 0, 1, 2'b10);
    b = put(b, 3, 1, 1, 2'b01); b = put(b, 3, 2, 2, 2'b01);
    run_move(1'b0, b, 2'b10, mk(1'b1, 0, 2, 2'b10), "win");
    b = 32'd0;
    b = put(b, 3, 0, 0, 2'b01); b = put(b, 3, 1, 1, 2'b01); b = put(b, 3, 0, 1, 2'b10);
    run_move(1'b0, b, 2'b10, mk(1'b1, 2, 2, 2'b10), "block");
    b = 32'd0;
    b = put(b, 3, 2, 0, 2'b10); b = put(b, 3, 2, 1, 2'b10);
    b = put(b, 3, 0, 0, 2'b01); b = put(b, 3, 0, 1, 2'b01);
    run_move(1'b0, b, 2'b10, mk(1'b1, 2, 2, 2'b10), "win_over_block_o");
    run_move(1'b0, b, 2'b01, mk(1'b1, 0, 2, 2'b01), "win_over_block_x");
    pat = '{1, 2, 1, 1, 2, 2, 2, 1, 1};
    b = 32'd0;
    for (int i = 0; i < 9; i++) b = put(b, 3, i / 3, i % 3, 2'(pat[i]));
    run_move(1'b0, b, 2'b01, mk(1'b0, 0, 0, 2'b01), "full_board");
    run_move(1'b0, 32'd0, 2'b00, mk(1'b0, 0, 0, 2'b00), "player_00");
    run_move(1'b0, 32'd0, 2'b11, mk(1'b0, 0, 0, 2'b11), "player_11");
  endtask

  task automatic test_reset_mid_scan();
    int dones;
    sel4 = 1'b0;
    board3 = 18'd0; player3 = 2'b10; start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({busy3, done3, mv3, row3, col3, xoro3} !== 9'd0)
      begin bad++; $display("FAIL mid_scan_reset outputs: got %b want 0", {busy3, done3, mv3, row3, col3, xoro3}); end
    reset = 1'b0;
    dones = 0;
    for (int k = 0; k < 15; k++) begin
      if (done3 || busy3) dones++;
      @(posedge clk); #1;
    end
    total++;
    if (dones !== 0) begin bad++; $display("FAIL mid_scan_reset activity: got %0d want 0", dones); end
  endtask

  task automatic test_restart_ignored();
    logic [31:0] b;
    int dones;
    exp_t got, want;
    sel4 = 1'b0;
    b = 32'd0;
    b = put(b, 3, 0, 0, 2'b10); b = put(b, 3, 0, 1, 2'b10);
    board3 = b[17:0]; player3 = 2'b10; start3 = 1'b1;
    sb.push_back(mk(1'b1, 0, 2, 2'b10));
    @(posedge clk); #1;
    start3 = 1'b0;
    repeat (2) @(posedge clk);
    #1 start3 = 1'b1; board3 = 18'h3ffff; player3 = 2'b01;
    @(posedge clk); #1;
    start3 = 1'b0;
    dones = 0;
    for (int k = 0; k < 25; k++) begin
      if (done3) begin
        dones++;
        if (dones == 1) begin
          want = sb.pop_front();
          got = {mv3, row3, col3, xoro3};
          total++;
          if (got !== want) begin bad++; $display("FAIL restart result: got %b want %b", got, want); end
        end
      end
      @(posedge clk); #1;
    end
    if (dones == 0) void'(sb.pop_front());
    total++;
    if (dones !== 1) begin bad++; $display("FAIL restart done count: got %0d want 1", dones); end
  endtask

  task automatic test_n4();
    logic [31:0] b;
    run_move(1'b1, 32'd0, 2'b01, mk(1'b1, 0, 0, 2'b01), "n4_corner");
    b = 32'hffff_ffff;
    b = put(b, 4, 3, 3, 2'b00);
    run_move(1'b1, b, 2'b01, mk(1'b1, 3, 3, 2'b01), "n4_last_cell");
  endtask

  task automatic test_random();
    logic [31:0] b;
    logic [1:0] p;
    int n, v;
    for (int t = 0; t < 16; t++) begin
      n = (t < 12) ? 3 : 4;
      b = 32'd0;
      for (int i = 0; i < n*n; i++) begin
        v = $urandom_range(0, 5);
        b = put(b, n, i / n, i % n, (v < 3) ? 2'b00 : 2'(v - 2));
      end
      p = 2'($urandom_range(1, 2));
      run_move(n == 4, b, p, model(b, p, n), "random");
    end
  endtask

  initial begin
    total = 0; bad = 0;
    reset = 1'b1; sel4 = 1'b0;
    start3 = 1'b0; start4 = 1'b0;
    board3 = '0; board4 = '0; player3 = 2'b00; player4 = 2'b00;
    test_reset();
    test_priority3();
    test_reset_mid_scan();
    test_restart_ignored();
    test_n4();
    test_random();
    total++;
    if (sb.size() !== 0) begin bad++; $display("FAIL scoreboard leftover: got %0d want 0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
